// File: rtl/reg_scoreboard.sv
// Register-occupancy scoreboard: one in-flight-writer counter per
// architectural register. Answers issue_ready for a micro-op's sources and
// destination, claims the destination on issue and releases on writeback.
module reg_scoreboard #(
  parameter int NUM_REGS = 33,
  parameter int NUM_SRC  = 3,
  parameter int NUM_WB   = 2,
  parameter int CNT_W    = 2,
  parameter int BYPASS   = 1,
  localparam int REG_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*REG_W-1:0] src_reg,
  input  logic                     dst_valid,
  input  logic [REG_W-1:0]         dst_reg,
  output logic                     issue_ready,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*REG_W-1:0]  wb_reg,
  input  logic                     flush,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic                     empty,
  output logic                     overflow_err,
  output logic                     underflow_err
);

  // Release counts need to hold 0..NUM_WB; the signed working width covers
  // counter + claim and counter - release without wrapping.
  localparam int REL_W = $clog2(NUM_WB + 1);
  localparam int SUM_W = CNT_W + REL_W + 1;
  localparam logic [CNT_W-1:0]        CNT_MAX = '1;
  localparam logic signed [SUM_W-1:0] MAX_S   = signed'({{(SUM_W-CNT_W){1'b0}}, CNT_MAX});

  logic [CNT_W-1:0] cnt     [NUM_REGS];
  logic [CNT_W-1:0] cnt_nxt [NUM_REGS];
  logic [REL_W-1:0] rel     [NUM_REGS];
  logic [NUM_REGS-1:0] eff_busy;
  logic raw_stall;
  logic sat_stall;
  logic claim_ok;
  logic empty_nxt;
  logic over_set;
  logic under_set;
  logic signed [SUM_W-1:0] tot;
  logic signed [SUM_W-1:0] rel_s;
  logic signed [SUM_W-1:0] applied;
  logic signed [SUM_W-1:0] net;

  function automatic logic signed [SUM_W-1:0] ext_cnt(input logic [CNT_W-1:0] c);
    return signed'({{(SUM_W-CNT_W){1'b0}}, c});
  endfunction

  function automatic logic signed [SUM_W-1:0] ext_rel(input logic [REL_W-1:0] r);
    return signed'({{(SUM_W-REL_W){1'b0}}, r});
  endfunction

  function automatic logic signed [SUM_W-1:0] ext_bit(input logic b);
    return signed'({{(SUM_W-1){1'b0}}, b});
  endfunction

  // A release can never take more than the counter holds (after this cycle's claim).
  function automatic logic signed [SUM_W-1:0] clamp_release(
    input logic signed [SUM_W-1:0] avail,
    input logic signed [SUM_W-1:0] req
  );
    return (req > avail) ? avail : req;
  endfunction

  // Saturate a non-negative working value into the counter range.
  function automatic logic [CNT_W-1:0] sat_cnt(input logic signed [SUM_W-1:0] v);
    if (v[SUM_W-1])
      return '0;
    else if (v > MAX_S)
      return CNT_MAX;
    else
      return v[CNT_W-1:0];
  endfunction

  // Per-register release count from all writeback ports; out-of-range indices match nothing.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      rel[r] = '0;
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid[p] && (wb_reg[p*REG_W +: REG_W] == REG_W'(r)))
          rel[r] = rel[r] + REL_W'(1);
      end
    end
  end

  // Effective busy per register, then RAW and saturation stall detection.
  always_comb begin
    eff_busy  = '0;
    raw_stall = 1'b0;
    sat_stall = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (BYPASS != 0)
        eff_busy[r] = ext_cnt(cnt[r]) > ext_rel(rel[r]);
      else
        eff_busy[r] = (cnt[r] != '0);
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (src_valid[i] && (src_reg[i*REG_W +: REG_W] == REG_W'(r)) && eff_busy[r])
          raw_stall = 1'b1;
      end
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      if (dst_valid && (dst_reg == REG_W'(r)) &&
          ((ext_cnt(cnt[r]) - ext_rel(rel[r])) == MAX_S))
        sat_stall = 1'b1;
    end
  end

  assign issue_ready = !flush && !raw_stall && !sat_stall;
  assign claim_ok    = issue_valid && issue_ready && dst_valid;

  // Next counter values: net of claim and clamped release; flush zeroes everything.
  always_comb begin
    over_set  = 1'b0;
    under_set = 1'b0;
    empty_nxt = 1'b1;
    tot       = '0;
    rel_s     = '0;
    applied   = '0;
    net       = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_nxt[r] = '0;
      if (!flush) begin
        tot     = ext_cnt(cnt[r]) + ext_bit(claim_ok && (dst_reg == REG_W'(r)));
        rel_s   = ext_rel(rel[r]);
        applied = clamp_release(tot, rel_s);
        net     = tot - applied;
        if (rel_s > tot)
          under_set = 1'b1;
        if (net > MAX_S)
          over_set = 1'b1;
        cnt_nxt[r] = sat_cnt(net);
      end
      if (cnt_nxt[r] != '0)
        empty_nxt = 1'b0;
    end
  end

  // Counter state, registered status outputs and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt[r] <= '0;
      busy_vec      <= '0;
      empty         <= 1'b1;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r]      <= cnt_nxt[r];
        busy_vec[r] <= (cnt_nxt[r] != '0);
      end
      empty         <= empty_nxt;
      overflow_err  <= overflow_err | over_set;
      underflow_err <= underflow_err | under_set;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus a random
// run, all compared against a counter-array reference model.
module tb_reg_scoreboard;

  localparam int NUM_REGS = 33;
  localparam int NUM_SRC  = 3;
  localparam int NUM_WB   = 2;
  localparam int CNT_W    = 2;
  localparam int BYPASS   = 1;
  localparam int REG_W    = 6;
  localparam int MAXC     = (1 << CNT_W) - 1;

  logic                     clk;
  logic                     reset;
  logic                     issue_valid;
  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC*REG_W-1:0] src_reg;
  logic                     dst_valid;
  logic [REG_W-1:0]         dst_reg;
  logic                     issue_ready;
  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*REG_W-1:0]  wb_reg;
  logic                     flush;
  logic [NUM_REGS-1:0]      busy_vec;
  logic                     empty;
  logic                     overflow_err;
  logic                     underflow_err;

  int total = 0;
  int bad   = 0;

  int cnt_m [NUM_REGS];
  bit over_m;
  bit under_m;

  reg_scoreboard #(
    .NUM_REGS(NUM_REGS), .NUM_SRC(NUM_SRC), .NUM_WB(NUM_WB),
    .CNT_W(CNT_W), .BYPASS(BYPASS)
  ) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .src_valid(src_valid), .src_reg(src_reg), .dst_valid(dst_valid),
    .dst_reg(dst_reg), .issue_ready(issue_ready), .wb_valid(wb_valid),
    .wb_reg(wb_reg), .flush(flush), .busy_vec(busy_vec), .empty(empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int src_at(int i);
    return int'(src_reg[i*REG_W +: REG_W]);
  endfunction

  function automatic int rel_m(int r);
    int n = 0;
    for (int p = 0; p < NUM_WB; p++)
      if (wb_valid[p] && int'(wb_reg[p*REG_W +: REG_W]) == r) n++;
    return n;
  endfunction

  function automatic bit ready_m();
    int s;
    int d;
    if (flush) return 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s = src_at(i);
      if (src_valid[i] && s < NUM_REGS) begin
        if (BYPASS != 0) begin
          if (cnt_m[s] > rel_m(s)) return 1'b0;
        end else begin
          if (cnt_m[s] != 0) return 1'b0;
        end
      end
    end
    d = int'(dst_reg);
    if (dst_valid && d < NUM_REGS && (cnt_m[d] - rel_m(d)) == MAXC) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [NUM_REGS-1:0] busy_m();
    logic [NUM_REGS-1:0] v = '0;
    for (int r = 0; r < NUM_REGS; r++) v[r] = (cnt_m[r] != 0);
    return v;
  endfunction

  task automatic reset_m();
    for (int r = 0; r < NUM_REGS; r++) cnt_m[r] = 0;
    over_m  = 1'b0;
    under_m = 1'b0;
  endtask

  task automatic step_m();
    bit rdy;
    int t;
    int rl;
    if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_m[r] = 0;
      return;
    end
    rdy = ready_m();
    for (int r = 0; r < NUM_REGS; r++) begin
      t  = cnt_m[r] + ((issue_valid && rdy && dst_valid && int'(dst_reg) == r) ? 1 : 0);
      rl = rel_m(r);
      if (rl > t) begin under_m = 1'b1; t = 0; end
      else t = t - rl;
      if (t > MAXC) begin over_m = 1'b1; t = MAXC; end
      cnt_m[r] = t;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    issue_valid = 1'b0; src_valid = '0; src_reg = '0;
    dst_valid = 1'b0; dst_reg = '0; wb_valid = '0; wb_reg = '0; flush = 1'b0;
  endtask

  task automatic set_src(input int i, input int r);
    src_valid[i] = 1'b1;
    src_reg[i*REG_W +: REG_W] = REG_W'(r);
  endtask

  task automatic set_wb(input int p, input int r);
    wb_valid[p] = 1'b1;
    wb_reg[p*REG_W +: REG_W] = REG_W'(r);
  endtask

  task automatic issue(input int r);
    issue_valid = 1'b1; dst_valid = 1'b1; dst_reg = REG_W'(r);
  endtask

  // Advance one clock: model consumes the inputs present at the edge.
  task automatic tick();
    if (!reset) reset_m(); else step_m();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    reset = 1'b0;
    reset_m();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    total++; if (busy_vec !== '0) begin bad++; $display("FAIL reset_busy: got %h want 0", busy_vec); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
    total++; if ({overflow_err, underflow_err} !== 2'b00) begin bad++; $display("FAIL reset_err: got %b want 00", {overflow_err, underflow_err}); end
  endtask

  task automatic test_raw();
    idle(); issue(3);
    tick();
    idle(); set_src(0, 3);
    #1;
    total++; if (busy_vec[3] !== 1'b1) begin bad++; $display("FAIL raw_busy3: got %b want 1", busy_vec[3]); end
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL raw_stall: got %b want 0", issue_ready); end
    tick();
    set_wb(0, 3);
    #1;
    total++; if (issue_ready !== (BYPASS != 0)) begin bad++; $display("FAIL raw_bypass: got %b want %b", issue_ready, BYPASS != 0); end
    tick();
    idle();
    #1;
    total++; if (busy_vec[3] !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL raw_release: busy3=%b empty=%b want 0 1", busy_vec[3], empty); end
  endtask

  task automatic test_saturation();
    idle();
    repeat (3) begin issue(5); tick(); end
    issue(5);
    #1;
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL sat_stall: got %b want 0", issue_ready); end
    tick();
    idle(); set_wb(0, 5); set_wb(1, 5);
    tick();
    idle();
    #1;
    total++; if (busy_vec[5] !== 1'b1 || empty !== 1'b0) begin bad++; $display("FAIL sat_dual_rel: busy5=%b empty=%b want 1 0", busy_vec[5], empty); end
    set_wb(0, 5);
    tick();
    idle();
    #1;
    total++; if (busy_vec[5] !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL sat_last_rel: busy5=%b empty=%b want 0 1", busy_vec[5], empty); end
    total++; if ({overflow_err, underflow_err} !== 2'b00) begin bad++; $display("FAIL sat_err: got %b want 00", {overflow_err, underflow_err}); end
  endtask

  task automatic test_claim_release();
    idle(); issue(7);
    tick();
    issue(7); set_wb(0, 7);
    #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL cr_ready: got %b want 1", issue_ready); end
    tick();
    idle();
    #1;
    total++; if (busy_vec[7] !== 1'b1) begin bad++; $display("FAIL cr_busy7: got %b want 1", busy_vec[7]); end
    total++; if ({overflow_err, underflow_err} !== 2'b00) begin bad++; $display("FAIL cr_err: got %b want 00", {overflow_err, underflow_err}); end
    set_wb(1, 7);
    tick();
    idle();
    #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL cr_empty: got %b want 1", empty); end
  endtask

  task automatic test_underflow_oor();
    idle(); set_wb(0, 9);
    tick();
    idle();
    #1;
    total++; if (underflow_err !== 1'b1) begin bad++; $display("FAIL uf_set: got %b want 1", underflow_err); end
    flush = 1'b1;
    tick();
    idle();
    #1;
    total++; if (underflow_err !== 1'b1) begin bad++; $display("FAIL uf_sticky: got %b want 1", underflow_err); end
    set_src(0, 40);
    #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL oor_src: got %b want 1", issue_ready); end
    idle(); issue(40);
    tick();
    idle();
    #1;
    total++; if (empty !== 1'b1 || busy_vec !== '0) begin bad++; $display("FAIL oor_dst: empty=%b busy=%h want 1 0", empty, busy_vec); end
  endtask

  task automatic test_flush_reset();
    idle(); issue(1); tick();
    issue(2); tick();
    issue(4); tick();
    idle();
    #1;
    total++; if (busy_vec !== 33'h16) begin bad++; $display("FAIL fl_claims: got %h want 16", busy_vec); end
    issue(6); flush = 1'b1;
    #1;
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL fl_ready: got %b want 0", issue_ready); end
    tick();
    idle();
    #1;
    total++; if (busy_vec !== '0 || empty !== 1'b1) begin bad++; $display("FAIL fl_clear: busy=%h empty=%b want 0 1", busy_vec, empty); end
    issue(1); tick();
    idle();
    #1;
    total++; if (busy_vec[1] !== 1'b1) begin bad++; $display("FAIL ar_pre: got %b want 1", busy_vec[1]); end
    #1 reset = 1'b0;
    #1;
    total++; if (busy_vec !== '0 || empty !== 1'b1 || underflow_err !== 1'b0) begin bad++; $display("FAIL ar_async: busy=%h empty=%b uf=%b want 0 1 0", busy_vec, empty, underflow_err); end
    reset_m();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  function automatic int rnd_reg();
    int k = int'($urandom_range(0, 19));
    if (k < 16) return int'($urandom_range(0, 7));
    return int'($urandom_range(30, 40));
  endfunction

  task automatic test_random();
    bit exp_rdy;
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int i = 0; i < NUM_SRC; i++)
        if ($urandom_range(0, 2) == 0) set_src(i, rnd_reg());
      if ($urandom_range(0, 3) != 0) begin
        issue_valid = ($urandom_range(0, 4) != 0);
        dst_valid = 1'b1; dst_reg = REG_W'(rnd_reg());
      end
      for (int p = 0; p < NUM_WB; p++)
        if ($urandom_range(0, 3) == 0) set_wb(p, rnd_reg());
      flush = ($urandom_range(0, 24) == 0);
      #1;
      exp_rdy = ready_m();
      total++; if (issue_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, issue_ready, exp_rdy); end
      tick();
      total++; if (busy_vec !== busy_m() || empty !== (busy_m() == '0)) begin bad++; $display("FAIL rnd_state[%0d]: busy=%h empty=%b want %h %b", c, busy_vec, empty, busy_m(), busy_m() == '0); end
      total++; if (overflow_err !== over_m || underflow_err !== under_m) begin bad++; $display("FAIL rnd_err[%0d]: got %b%b want %b%b", c, overflow_err, underflow_err, over_m, under_m); end
    end
  endtask

  initial begin
    reset = 1'b0;
    idle();
    reset_m();
    test_reset();
    test_raw();
    test_saturation();
    test_claim_release();
    test_underflow_oor();
    test_flush_reset();
    test_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
